// File: rtl/pacman_irq_pkg.sv
// pacman_irq_pkg: shared register map and source indices for the Pacman IRQ controller
// Ports: none (package of localparams only).
package pacman_irq_pkg;
    localparam logic [3:0] ADDR_PENDING  = 4'd0;
    localparam logic [3:0] ADDR_MASK     = 4'd1;
    localparam logic [3:0] ADDR_VECTOR   = 4'd2;
    localparam logic [3:0] ADDR_RAW      = 4'd3;
    localparam logic [3:0] ADDR_OVR_BASE = 4'd4;
    localparam int VEC_VALID_BIT = 15;
    localparam int SRC_TIMER     = 0;
    localparam int SRC_VSYNC     = 1;
    localparam int SRC_KEYBOARD  = 2;
endpackage

// File: rtl/pacman_irq_ctrl_if.sv
// pacman_irq_ctrl_if: Avalon-MM slave bus of the IRQ controller
// Signals: chipselect, address[3:0], write_n (active low), writedata[15:0], readdata[15:0].
// Modports: master drives the bus, slave is the controller side.
interface pacman_irq_ctrl_if;
    logic        chipselect;
    logic [3:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    modport master (output chipselect, address, write_n, writedata, input readdata);
    modport slave (input chipselect, address, write_n, writedata, output readdata);
endinterface

// File: rtl/pacman_irq_ctrl_irq_src_slice.sv
// irq_src_slice: per-source edge detect, sticky pending bit and saturating overrun counter
// Ports: clk, reset (sync, active high), irq_in (level), clr_pend (W1C hit for this bit),
//        clr_ovr (write to this counter), pending/pending_next, ovr (counter value).
module irq_src_slice #(
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    input  logic             clr_pend,
    input  logic             clr_ovr,
    output logic             pending,
    output logic             pending_next,
    output logic [OVR_W-1:0] ovr
);
    logic irq_prev;
    logic rise;
    logic inc;
    logic [OVR_W-1:0] ovr_next;
    assign rise = irq_in & ~irq_prev;
    // An edge landing on an already pending bit is a missed tick unless software clears it now.
    assign inc = rise & pending & ~clr_pend;
    assign pending_next = rise | (pending & ~clr_pend);
    assign ovr_next = clr_ovr ? OVR_W'(inc) : (inc && !(&ovr)) ? ovr + 1'b1 : ovr;
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= 1'b0;
            pending  <= 1'b0;
            ovr      <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= pending_next;
            ovr      <= ovr_next;
        end
    end
endmodule

// File: rtl/pacman_irq_ctrl.sv
// pacman_irq_ctrl: Avalon-MM interrupt aggregator with mask, priority vector and overrun counters
// Ports: clk, reset (sync, active high), irq_in[N_SRC] level IRQs (bit 0 = timer),
//        bus (Avalon slave modport), irq_out (registered combined interrupt).
module pacman_irq_ctrl
    import pacman_irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int OVR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_in,
    pacman_irq_ctrl_if.slave   bus,
    output logic               irq_out
);
    logic             wr;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mask_next;
    logic [N_SRC-1:0] act;
    logic [OVR_W-1:0] ovr [N_SRC];
    logic [2:0]       vec_id;
    logic [15:0]      rd_mux;
    logic             unused_wdata;
    assign wr = bus.chipselect & ~bus.write_n;
    assign mask_next = (wr && bus.address == ADDR_MASK) ? bus.writedata[N_SRC-1:0] : mask;
    assign act = pending & mask;
    assign unused_wdata = &{1'b0, bus.writedata[15:N_SRC]};
    genvar g;
    for (g = 0; g < N_SRC; g++) begin : g_src
        irq_src_slice #(.OVR_W(OVR_W)) u_src (
            .clk          (clk),
            .reset        (reset),
            .irq_in       (irq_in[g]),
            .clr_pend     (wr && bus.address == ADDR_PENDING && bus.writedata[g]),
            .clr_ovr      (wr && bus.address == 4'(ADDR_OVR_BASE + g)),
            .pending      (pending[g]),
            .pending_next (pending_next[g]),
            .ovr          (ovr[g])
        );
    end
    // Scan downwards so the lowest active index (highest priority) wins.
    always_comb begin
        vec_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (act[i]) vec_id = 3'(i);
    end
    // Read mux sees pre-write state; readdata registers it every cycle.
    always_comb begin
        rd_mux = '0;
        if (bus.address == ADDR_PENDING) rd_mux = 16'(pending);
        if (bus.address == ADDR_MASK)    rd_mux = 16'(mask);
        if (bus.address == ADDR_VECTOR)  rd_mux = (16'(|act) << VEC_VALID_BIT) | 16'(vec_id);
        if (bus.address == ADDR_RAW)     rd_mux = 16'(irq_in);
        for (int i = 0; i < N_SRC; i++)
            if (bus.address == 4'(ADDR_OVR_BASE + i)) rd_mux = 16'(ovr[i]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mask         <= '0;
            irq_out      <= 1'b0;
            bus.readdata <= '0;
        end else begin
            mask         <= mask_next;
            irq_out      <= |(pending_next & mask_next);
            bus.readdata <= rd_mux;
        end
    end
endmodule
